// File: rtl/ser_ctrl.sv
// Word-boundary arbiter/formatter for a 10/8-bit serializer: two requesters, burst-limited round robin.
// Optional SER_CTRL_STAT_EN adds idle_cnt, a saturating count of idle words sent.
module ser_ctrl #(
   parameter logic [9:0] IDLE_WORD = 10'h0FA,
   parameter int         MAX_BURST = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       mode_req,
   output logic       div10,
   input  logic       req_a,
   input  logic       req_b,
   input  logic [9:0] data_a,
   input  logic [9:0] data_b,
   output logic       ack_a,
   output logic       ack_b,
   output logic [9:0] word,
   output logic       word_vld
`ifdef SER_CTRL_STAT_EN
  ,output logic [15:0] idle_cnt
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_OWN_A, S_OWN_B} state_t;

   localparam logic [3:0] MAXB = 4'(MAX_BURST);

   state_t     r_state, w_state_nxt;
   logic [3:0] r_burst, w_burst_nxt;
   logic       r_last_b;
   logic       w_gnt_a, w_gnt_b;
   logic [9:0] w_sel, w_word_fmt;

   always_comb begin
      w_gnt_a     = 1'b0;
      w_gnt_b     = 1'b0;
      w_state_nxt = S_IDLE;
      w_burst_nxt = 4'd0;
      if (req_a && req_b) begin
         case (r_state)
            S_OWN_A: if (r_burst < MAXB) w_gnt_a = 1'b1; else w_gnt_b = 1'b1;
            S_OWN_B: if (r_burst < MAXB) w_gnt_b = 1'b1; else w_gnt_a = 1'b1;
            default: if (r_last_b) w_gnt_a = 1'b1; else w_gnt_b = 1'b1;
         endcase
      end else begin
         w_gnt_a = req_a;
         w_gnt_b = req_b;
      end
      if (w_gnt_a) w_state_nxt = S_OWN_A;
      else if (w_gnt_b) w_state_nxt = S_OWN_B;
      // Same owner again extends the burst; a new owner restarts it at 1.
      if (w_gnt_a || w_gnt_b) begin
         if (w_state_nxt == r_state)
            w_burst_nxt = (r_burst >= MAXB) ? MAXB : r_burst + 4'd1;
         else
            w_burst_nxt = 4'd1;
      end
   end

   assign w_sel      = w_gnt_a ? data_a : (w_gnt_b ? data_b : IDLE_WORD);
   assign w_word_fmt = mode_req ? w_sel : {2'b00, w_sel[7:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_burst  <= 4'd0;
         r_last_b <= 1'b1;
         div10    <= 1'b0;
         word     <= 10'h000;
         word_vld <= 1'b0;
         ack_a    <= 1'b0;
         ack_b    <= 1'b0;
      end else begin
         ack_a <= 1'b0;
         ack_b <= 1'b0;
         if (load) begin
            r_state  <= w_state_nxt;
            r_burst  <= w_burst_nxt;
            div10    <= mode_req;
            word     <= w_word_fmt;
            word_vld <= w_gnt_a | w_gnt_b;
            ack_a    <= w_gnt_a;
            ack_b    <= w_gnt_b;
            if (w_gnt_a || w_gnt_b) r_last_b <= w_gnt_b;
         end
      end
   end

`ifdef SER_CTRL_STAT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         idle_cnt <= 16'h0000;
      else if (load && !w_gnt_a && !w_gnt_b && idle_cnt != 16'hFFFF)
         idle_cnt <= idle_cnt + 16'h0001;
   end
`endif

endmodule

// File: tb/tb_ser_ctrl.sv
// Scoreboarded bench for ser_ctrl: driver runs a grant-history model, monitor compares after each edge.
module tb_ser_ctrl;
   localparam int MAXB = 4;
   localparam logic [9:0] IDLEW = 10'h0FA;

   logic       clk = 1'b0;
   logic       rs, ld, md, ra, rb;
   logic [9:0] da, db;
   logic       div10, ack_a, ack_b, word_vld;
   logic [9:0] word;
`ifdef SER_CTRL_STAT_EN
   logic [15:0] idle_cnt;
`endif

   ser_ctrl #(.IDLE_WORD(IDLEW), .MAX_BURST(MAXB)) dut (
      .clk(clk), .rst(rs), .load(ld), .mode_req(md), .div10(div10),
      .req_a(ra), .req_b(rb), .data_a(da), .data_b(db),
      .ack_a(ack_a), .ack_b(ack_b), .word(word), .word_vld(word_vld)
`ifdef SER_CTRL_STAT_EN
     ,.idle_cnt(idle_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]  word;
      logic        vld, div, aa, ab;
      logic [15:0] idle;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0, n_err = 0;

   // model state: who sent the last word (0 idle, 1 A, 2 B), its run length, last granted
   int          m_own = 0, m_run = 0, m_last = 2, m_gnt = 0;
   exp_t        e = '{10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};

   function automatic logic [9:0] fmt(input logic m, input logic [9:0] d);
      return m ? d : {2'b00, d[7:0]};
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
      n_vec++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
      end
   endtask

   task automatic model();
      int g;
      m_gnt = 0;
      if (rs) begin
         e = '{10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
         m_own = 0; m_run = 0; m_last = 2;
         return;
      end
      e.aa = 1'b0; e.ab = 1'b0;
      if (!ld) return;
      if (ra && rb) g = (m_own != 0) ? ((m_run < MAXB) ? m_own : 3 - m_own) : 3 - m_last;
      else g = ra ? 1 : (rb ? 2 : 0);
      e.div = md;
      if (g == 0) begin
         e.word = fmt(md, IDLEW); e.vld = 1'b0;
         m_own = 0; m_run = 0;
         if (e.idle != 16'hFFFF) e.idle++;
      end else begin
         m_run = (g == m_own) ? ((m_run + 1 > MAXB) ? MAXB : m_run + 1) : 1;
         m_own = g; m_last = g; m_gnt = g;
         e.word = fmt(md, (g == 1) ? da : db); e.vld = 1'b1;
         e.aa = (g == 1); e.ab = (g == 2);
      end
   endtask

   task automatic step(input logic l, m, a, b, input logic [9:0] dA, dB, input logic r);
      logic prev_rs;
      @(negedge clk);
      prev_rs = rs;
      ld = l; md = m; ra = a; rb = b; da = dA; db = dB; rs = r;
      if (r && !prev_rs) begin
         #1;
         chk("async_rst_word", {6'h0, word}, 16'h0);
         chk("async_rst_ctl", {12'h0, word_vld, div10, ack_a, ack_b}, 16'h0);
      end
      model();
      q.push_back(e);
   endtask

   // monitor: one expected entry per clock edge
   initial begin
      exp_t x;
      forever begin
         @(posedge clk); #1;
         if (q.size() != 0) begin
            x = q.pop_front();
            chk("word", {6'h0, word}, {6'h0, x.word});
            chk("word_vld", {15'h0, word_vld}, {15'h0, x.vld});
            chk("div10", {15'h0, div10}, {15'h0, x.div});
            chk("ack_a", {15'h0, ack_a}, {15'h0, x.aa});
            chk("ack_b", {15'h0, ack_b}, {15'h0, x.ab});
            chk("ack_excl", {15'h0, ack_a & ack_b}, 16'h0);
`ifdef SER_CTRL_STAT_EN
            chk("idle_cnt", idle_cnt, x.idle);
`endif
         end
      end
   end

   initial begin
      logic a, b, m;
      logic [9:0] dA, dB;
      int lim;
      rs = 1'b1; ld = 1'b0; md = 1'b0; ra = 1'b0; rb = 1'b0; da = '0; db = '0;
      repeat (3) step(1, 1, 1, 1, 10'h111, 10'h222, 1);
      // idle loads every 10 cycles (3 idle loads, then one data load below)
      for (int k = 0; k < 3; k++) begin
         repeat (9) step(0, 1, 0, 0, 10'h0, 10'h0, 0);
         step(1, 1, 0, 0, 10'h0, 10'h0, 0);
      end
      // 8-bit single request
      step(0, 0, 1, 0, 10'h3A5, 10'h0, 0);
      step(1, 0, 1, 0, 10'h3A5, 10'h0, 0);
      repeat (3) step(0, 0, 0, 0, 10'h3A5, 10'h0, 0);
      // both requesting continuously in 10-bit mode, load every 3 cycles
      dA = 10'h301; dB = 10'h102;
      for (int k = 0; k < 12; k++) begin
         step(0, 1, 1, 1, dA, dB, 0);
         step(0, 1, 1, 1, dA, dB, 0);
         step(1, 1, 1, 1, dA, dB, 0);
         dA = dA + 10'd1; dB = dB + 10'd1;
      end
      // mode toggles between loads
      step(1, 0, 1, 0, 10'h2C3, 10'h0, 0);
      step(0, 1, 0, 0, 10'h2C3, 10'h0, 0);
      step(0, 1, 0, 0, 10'h2C3, 10'h0, 0);
      step(1, 1, 1, 0, 10'h2C3, 10'h0, 0);
      step(0, 0, 0, 0, 10'h0, 10'h0, 0);
      // consecutive loads
      step(1, 1, 1, 1, 10'h155, 10'h2AA, 0);
      step(1, 1, 1, 1, 10'h156, 10'h2AB, 0);
      step(1, 1, 0, 1, 10'h156, 10'h2AC, 0);
      // reset during a B burst, then both request: A first
      lim = 0;
      while (!(m_own == 2 && m_run >= 2) && lim < 40) begin
         step(1, 1, 1, 1, 10'h0F0, 10'h00F, 0);
         lim++;
      end
      chk("reach_b_burst", 16'(m_own), 16'd2);
      step(0, 1, 1, 1, 10'h0F0, 10'h00F, 1);
      step(0, 1, 1, 1, 10'h0F0, 10'h00F, 1);
      step(1, 1, 1, 1, 10'h0F0, 10'h00F, 0);
      step(0, 1, 0, 1, 10'h0F0, 10'h00F, 0);
      // randomized traffic
      a = 0; b = 0; m = 1; dA = 0; dB = 0;
      for (int k = 0; k < 2000; k++) begin
         if ($urandom % 16 == 0) m = ~m;
         if (m_gnt == 1 || !a) begin a = 1'($urandom % 2); dA = 10'($urandom); end
         else if ($urandom % 32 == 0) a = 1'b0;
         if (m_gnt == 2 || !b) begin b = 1'($urandom % 2); dB = 10'($urandom); end
         else if ($urandom % 32 == 0) b = 1'b0;
         step(1'($urandom % 3 == 0), m, a, b, dA, dB, 1'($urandom % 200 == 0));
      end
      step(0, m, 0, 0, dA, dB, 0);
      lim = 0;
      while (q.size() != 0 && lim < 10) begin @(negedge clk); lim++; end
      chk("drain", 16'(q.size()), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/ser_ctrl.md
SER_CTRL -- requirements
Module: ser_ctrl

Interface
REQ-001 Parameter IDLE_WORD, default 10'h0FA, comma/idle word sent when no requester is granted.
REQ-002 Parameter MAX_BURST, default 4, range 1..15, maximum consecutive words granted to one requester while the other is waiting.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 load  input  1  one-cycle word-boundary strobe from the serializer divider.
REQ-006 mode_req  input  1  requested word mode: 1 = 10-bit, 0 = 8-bit.
REQ-007 div10  output  1  word-length select driven to the serializer divider.
REQ-008 req_a / req_b  input  1 each  requester word valid, held high until acked.
REQ-009 data_a / data_b  input  10 each  requester word; only bits [7:0] are used in 8-bit mode.
REQ-010 ack_a / ack_b  output  1 each  one-cycle grant acknowledge.
REQ-011 word  output  10  parallel word presented to the serializer shift register.
REQ-012 word_vld  output  1  1 = word carries requester data, 0 = idle word.

Function
REQ-013 All decisions occur only at a rising clk edge where load==1. Between loads, word, word_vld, div10 and the arbiter state shall hold.
REQ-014 At a load edge, div10 shall take mode_req, and the word latched at that same edge shall be formatted for the new mode.
REQ-015 Formatting shall be: 10-bit mode word=data; 8-bit mode word={2'b00,data[7:0]}; idle in 8-bit mode word={2'b00,IDLE_WORD[7:0]}.
REQ-016 FSM states: IDLE (last word idle), OWN_A, OWN_B (last word from that requester).
REQ-017 At a load edge with no request, word=IDLE_WORD (formatted), word_vld=0, next state IDLE, burst counter cleared.
REQ-018 At a load edge with only one request, that requester shall be granted.
REQ-019 At a load edge with both requesting:
  - In OWN_x with burst count < MAX_BURST, grant x.
  - In OWN_x otherwise, grant the other requester.
  - In IDLE, grant the requester not granted most recently; A wins after reset.
REQ-020 On grant: word=data of the granted requester, word_vld=1, the matching ack high for exactly the cycle after the load edge, state OWN_granted.
REQ-021 Burst counter: set to 1 when ownership changes; incremented when the same owner is granted again; saturates at MAX_BURST; width 4 bits.
REQ-022 ack_a and ack_b shall never be high in the same cycle, and there shall be at most one ack per load.
REQ-023 A req dropped between loads without an ack is legal; the requester shall simply not be granted.
REQ-024 load asserted on consecutive cycles shall be treated as two independent word boundaries.

Reset
REQ-025 While rst is high, all outputs and state shall be forced:
  - word=10'h000, word_vld=0, ack_a=ack_b=0, div10=0
  - state IDLE, burst counter 0, last-granted = B (so A wins first).
REQ-026 Reset asserted mid-burst shall abort immediately with no ack issued. The first load after release shall follow REQ-017..REQ-020.

Configuration
REQ-027 Macro SER_CTRL_STAT_EN gates one feature.
  - Defined: add output idle_cnt[15:0], which counts load edges that send an idle word, saturates at 16'hFFFF, and resets to 0.
  - Undefined: port and counter are absent; all other behaviour is identical.

Verification
REQ-028 Reset, then load every 10 cycles with no req -> word=10'h0FA, word_vld=0, no acks.
REQ-029 mode_req=0, req_a with data_a=10'h3A5 -> at next load word=10'h0A5, word_vld=1, ack_a high 1 cycle, div10=0.
REQ-030 Both req continuously, MAX_BURST=4, mode 10-bit -> grant sequence A,A,A,A,B,B,B,B,A...
REQ-031 mode_req toggled 0->1 between loads -> div10 changes only at the next load edge, and that word is 10-bit formatted.
REQ-032 rst pulsed during a B burst -> outputs zero at once, and the first grant after release is A when both request.
REQ-033 With SER_CTRL_STAT_EN, 3 idle loads then 1 data load -> idle_cnt=3.
